// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared constants for the FIFO round-robin drain arbiter.
// State encoding and default widths shared with the upstream FIFOs.
package fifo_rr_arbiter_pkg;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_DATA_W = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_PAUSE  = 2'd2;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first request at or after ptr+1,
// wrapping cyclically; ptr itself has the lowest priority.
module fifo_rr_arbiter_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ptr + ID_W'(k);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains N_IN registered-read FIFOs round-robin, one word per clock,
// forwarding each popped word one cycle later with its source tag.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = $clog2(N_IN),
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   RESET_L,
    input  logic [N_IN-1:0]        fifo_empty,
    input  logic [N_IN-1:0]        fifo_err,
    input  logic [N_IN*DATA_W-1:0] fifo_data,
    input  logic                   dest_pause,
    output logic [N_IN-1:0]        fifo_rd,
    output logic [DATA_W-1:0]      data_out,
    output logic [ID_W-1:0]        src_id,
    output logic                   out_wr,
    output logic                   idle,
    output logic                   err,
    output logic [CNT_W-1:0]       fwd_count
);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             out_wr_q, out_wr_d;
    logic [ID_W-1:0]  src_id_q, src_id_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_IN-1:0]  req;
    logic [N_IN-1:0]  gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_valid;
    logic             any_req;
    logic             pop;

    assign req     = ~fifo_empty;
    assign any_req = |req;

    fifo_rr_arbiter_rr_pick #(
        .N    (N_IN),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Pause gates the pop in the same cycle it rises.
    assign pop = (state_q == ST_ACTIVE) && !dest_pause && pick_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dest_pause)   state_d = ST_PAUSE;
                else if (any_req) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (dest_pause)    state_d = ST_PAUSE;
                else if (!any_req) state_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!dest_pause) state_d = any_req ? ST_ACTIVE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = pop ? pick_idx : ptr_q;
        out_wr_d = pop;
        src_id_d = pop ? pick_idx : src_id_q;
        err_d    = err_q | (|fifo_err);
        cnt_d    = cnt_q + CNT_W'(out_wr_q);
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q  <= ST_IDLE;
            ptr_q    <= ID_W'(N_IN - 1);
            out_wr_q <= 1'b0;
            src_id_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            out_wr_q <= out_wr_d;
            src_id_q <= src_id_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Read data arrives one cycle after the pop, so the word is taken
    // straight from the FIFO's registered output during the strobe cycle.
    assign fifo_rd   = pop ? gnt : '0;
    assign out_wr    = out_wr_q;
    assign src_id    = src_id_q;
    assign data_out  = out_wr_q ? fifo_data[src_id_q*DATA_W +: DATA_W] : '0;
    assign idle      = (state_q == ST_IDLE);
    assign err       = err_q;
    assign fwd_count = cnt_q;

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Downstream consumer of N_IN parallel fifo instances. Every cycle it pops at most one word, choosing the source by round-robin among the non-empty FIFOs.
- Each popped word is forwarded one cycle later to the next stage with a write strobe and a source tag.
- Honours a downstream pause (almost-full) and flags upstream overflow/underflow errors.

Parameters:
- N_IN, 4, number of upstream FIFOs (power of 2, 2..8).
- DATA_W, 6, word width; matches fifo data width.
- ID_W, 2, source-tag width; equals log2(N_IN).
- CNT_W, 8, width of forwarded-word counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- RESET_L  in  1  asynchronous, active-low reset.
- fifo_empty  in  N_IN  per-FIFO empty flags; bit i belongs to FIFO i.
- fifo_err  in  N_IN  per-FIFO err_full flags.
- fifo_data  in  N_IN*DATA_W  packed read data; FIFO i occupies bits [i*DATA_W +: DATA_W].
- dest_pause  in  1  downstream almost-full; no new pop may be issued while high.
- fifo_rd  out  N_IN  one-hot pop strobes.
- data_out  out  DATA_W  forwarded word.
- src_id  out  ID_W  index of the FIFO that supplied data_out.
- out_wr  out  1  data_out/src_id valid this cycle; drives downstream fifo_wr.
- idle  out  1  FSM in IDLE.
- err  out  1  sticky error.
- fwd_count  out  CNT_W  number of words forwarded, wraps.

Behaviour:
Reset (RESET_L low, asynchronous):
- fifo_rd=0, out_wr=0, data_out=0, src_id=0, err=0, fwd_count=0, idle=1.
- Grant pointer resets to N_IN-1, so the first grant goes to FIFO 0.
- Reset mid-transfer discards any in-flight pop. No out_wr is issued after reset releases for a pop made before reset.

Read timing:
- FIFO read data is registered. A pop asserted in cycle N returns its word on fifo_data in cycle N+1.
- out_wr is asserted in cycle N+1, with data_out and src_id registered from that slice. Pop-to-out_wr latency is exactly 1 cycle.

FSM states: IDLE, ACTIVE, PAUSE.
- IDLE -> ACTIVE when any fifo_empty bit is 0 and dest_pause=0.
- IDLE -> PAUSE when dest_pause=1.
- ACTIVE -> PAUSE when dest_pause=1.
- ACTIVE -> IDLE when all FIFOs are empty and dest_pause=0.
- PAUSE -> IDLE when dest_pause=0 and all FIFOs are empty.
- PAUSE -> ACTIVE when dest_pause=0 and at least one FIFO is non-empty.
- Pops are issued only in ACTIVE, decided combinationally in the same cycle as the state. This gives zero extra bubble on entry.

Grant selection:
- The grant is the first i with fifo_empty[i]=0, searching cyclically from pointer+1.
- On a pop, the pointer is updated to the granted index.
- If no FIFO is non-empty, no pop is issued and the pointer is held.
- At most one fifo_rd bit is high in any cycle. fifo_rd[i] is never asserted while fifo_empty[i]=1.

Boundary conditions:
- A FIFO holding one word may be granted again in the next cycle only if its fifo_empty is still 0; it is not, because the FIFO's count update is registered.
- Pause takes effect in the same cycle dest_pause rises; no pop is issued. A pop issued in the previous cycle still produces its out_wr, which is why downstream must assert pause while at least one slot remains free.
- Back-to-back pops are allowed every cycle, so throughput is 1 word/clk.

Error and counter:
- err is set when any fifo_err bit is high and held until reset.
- fwd_count increments on each out_wr and wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package: the FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, PAUSE=2'd2) and the default DATA_W/N_IN constants used by fifo and this block.
- One natural sub-module: rr_pick, a combinational rotate-priority encoder. Inputs are the request vector and the pointer; outputs are the one-hot grant and its index.

Test Plan:
1. Reset, all FIFOs empty -> idle=1, fifo_rd=0, out_wr never asserted over 20 cycles.
2. FIFO0 and FIFO2 each hold 3 words (0x01..0x03 and 0x21..0x23), no pause.
   - Required pop order: 0,2,0,2,0,2.
   - Required out_wr stream: (0x01,id0),(0x21,id2),(0x02,id0),... with 1-cycle lag.
   - fwd_count=6 at the end.
3. All 4 FIFOs full (8 words each) -> 32 consecutive out_wr cycles with src_id 0,1,2,3 repeating, then return to IDLE.
4. dest_pause raised in the cycle after a pop -> exactly one out_wr follows (the in-flight word) and no fifo_rd while paused. Dropping pause resumes with the next index in rotation.
5. Pulse fifo_err[3] for one cycle -> err=1 and stays 1 until RESET_L pulses low.
6. Assert RESET_L low asynchronously in the cycle a pop is issued -> outputs clear immediately, no out_wr after release, and the first grant after release is FIFO 0.
